instr_fetch: RTL and testbench

Fetch-side initiator for the synchronous instruction memory. Owns the program counter, drives the word address into the memory every cycle and tracks the one-cycle read latency. Buffers returned words in a 2-entry queue and presents them to decode with a valid/ready handshake. Supports back-pressure and PC redirects (branch/jump/trap) without ever delivering a stale instruction.

---
 rtl/types_pkg.sv | 32 +++
 rtl/instr_fetch_if.sv | 44 ++++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/instr_fetch.sv | 93 +++++++++
 tb/tb_instr_fetch.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : types_pkg
// Description : Shared types and constants for the instruction-fetch slice:
//               memory geometry, word/address types and the fetch queue entry.
// Revision    : 1.0 - initial release
// ============================================================================
package types_pkg;

    // Instruction memory geometry (words)
    localparam int MEM_SIZE    = 512;
    localparam int ADDR_W      = $clog2(MEM_SIZE);

    // Fetch queue geometry
    localparam int FETCH_DEPTH = 2;
    localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);
    localparam int PTR_W       = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;

    typedef logic [ADDR_W-1:0] address_t;
    typedef logic [31:0]       word_t;

    // Queue occupancy, and occupancy with one extra bit for in-flight sums
    typedef logic [CNT_W-1:0]  fetch_cnt_t;
    typedef logic [CNT_W:0]    fetch_occ_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundle of the instruction-memory request/response signals,
//               the redirect request and the decode-side valid/ready port.
//               master = fetch unit, slave = memory/decode/redirect side.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
    import types_pkg::*;

    address_t imem_addr;
    word_t    imem_rdata;
    logic     redirect_valid;
    word_t    redirect_pc;
    logic     out_valid;
    logic     out_ready;
    word_t    out_instr;
    word_t    out_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO of fetched {instr, pc} entries.
//               Flush empties the queue and wins over a same-cycle push.
//               Storage is zeroed only by reset so the head reads 0 then.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import types_pkg::*;
(
    input  wire          clk,
    input  wire          rst_n,
    input  wire          i_push,
    input  wire          i_pop,
    input  wire          i_flush,
    input  fetch_entry_t i_data,
    output fetch_cnt_t   o_count,
    output fetch_entry_t o_head
);

    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(FETCH_DEPTH - 1);
    localparam fetch_cnt_t       c_FULL     = CNT_W'(FETCH_DEPTH);

    fetch_entry_t     r_mem [FETCH_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    fetch_cnt_t       r_count;

    logic w_do_pop;
    logic w_do_push;

    // A push into a full queue is only accepted when the head leaves at the same time
    assign w_do_pop  = i_pop  && !i_flush && (r_count != '0);
    assign w_do_push = i_push && !i_flush && ((r_count != c_FULL) || w_do_pop);

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Entry storage: cleared on reset, written at the tail on push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; flush returns the queue to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch initiator for a synchronous instruction memory with a
//               one-cycle read latency. Owns the PC, tracks the in-flight
//               request, buffers returned words and hands them to decode over
//               valid/ready. Redirects flush everything and restart the
//               stream in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
)(
    input  wire           clk,
    input  wire           rst_n,
    instr_fetch_if.master bus
);

    // Low PC bits never reach memory; keep them zero in the register too
    localparam word_t      c_RESET_PC = RESET_PC & ~32'h3;
    localparam fetch_occ_t c_DEPTH    = fetch_occ_t'(FETCH_DEPTH);

    word_t        r_pc;
    logic         r_inflight;
    word_t        r_inflight_pc;

    word_t        w_redirect_pc;
    logic         w_pop;
    logic         w_push;
    logic         w_issue;
    fetch_occ_t   w_occupancy;
    fetch_cnt_t   w_count;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;

    assign w_redirect_pc = bus.redirect_pc & ~32'h3;

    // Nothing transfers in a redirect cycle: the head belongs to the old stream
    assign bus.out_valid = (w_count != '0) && !bus.redirect_valid;
    assign w_pop         = bus.out_valid && bus.out_ready;

    // Slots already claimed (queued + in flight), crediting the word leaving now.
    // pop implies count >= 1, so the subtraction cannot underflow.
    assign w_occupancy = {1'b0, w_count}
                       + {{CNT_W{1'b0}}, r_inflight}
                       - {{CNT_W{1'b0}}, w_pop};
    assign w_issue     = bus.redirect_valid || (w_occupancy < c_DEPTH);

    // A response arriving during a redirect belongs to the old stream
    assign w_push       = r_inflight && !bus.redirect_valid;
    assign w_push_entry = '{instr: bus.imem_rdata, pc: r_inflight_pc};

    // The redirect target is requested in the same cycle it is presented
    assign bus.imem_addr = bus.redirect_valid ? w_redirect_pc[ADDR_W+1:2]
                                              : r_pc[ADDR_W+1:2];

    assign bus.out_instr = w_head.instr;
    assign bus.out_pc    = w_head.pc;

    // PC and in-flight tracking; redirect overrides the normal issue decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= c_RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            r_pc          <= w_redirect_pc + 32'd4;
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_redirect_pc;
        end else if (w_issue) begin
            r_pc          <= r_pc + 32'd4;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight    <= 1'b0;
        end
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_data  (w_push_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed, table-driven bench for instr_fetch. Instance A
//               (RESET_PC = 0) runs the cycle table: streaming,
//               back-pressure, redirects, async reset. Instance B
//               (RESET_PC = 0x7FC) covers address wrap and a mid-cycle reset.
//               Memory model: mem[i] = 0x100 + i, one-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
    import types_pkg::*;

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] epc;
        logic [8:0]  ea;
    } vec_t;

    logic        clk;
    logic        rst_n_a;
    logic        rst_n_b;
    logic [31:0] mem [MEM_SIZE];
    vec_t        vecs [$];
    int          n_checks;
    int          n_fail;

    instr_fetch_if bus_a ();
    instr_fetch_if bus_b ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a.master)
    );

    instr_fetch #(.RESET_PC(32'h0000_07FC)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memories, one per instance
    always @(posedge clk) begin
        bus_a.imem_rdata <= mem[bus_a.imem_addr];
        bus_b.imem_rdata <= mem[bus_b.imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic ev, input logic [31:0] ei,
                                input logic [31:0] epc, input logic [8:0] ea);
        vec_t v;
        v.rst_n = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.ei = ei; v.epc = epc; v.ea = ea;
        vecs.push_back(v);
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'h100 + i;

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc    = '0;
        bus_a.out_ready      = 1'b1;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = '0;
        bus_b.out_ready      = 1'b1;

        // ---------------- cycle table for instance A ----------------
        // Reset, then streaming: out_valid from cycle 2, no bubbles
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 1);
        for (int k = 2; k < 22; k++)
            add(1, 0, 0, 1, 1, 32'h100 + k - 2, 32'(4 * (k - 2)), 9'(k));

        // Reset again, then back-pressure after the first transfer
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1, 32'h100, 32'h0, 2);
        for (int k = 0; k < 5; k++)
            add(1, 0, 0, 0, 1, 32'h101, 32'h4, 3);
        add(1, 0, 0, 1, 1, 32'h101, 32'h4,  3);
        add(1, 0, 0, 1, 1, 32'h102, 32'h8,  4);
        add(1, 0, 0, 1, 1, 32'h103, 32'hC,  5);
        add(1, 0, 0, 1, 1, 32'h104, 32'h10, 6);
        add(1, 0, 0, 1, 1, 32'h105, 32'h14, 7);

        // Redirect to 0x40 while streaming
        add(1, 1, 32'h40, 1, 0, 0, 0, 16);
        add(1, 0, 0,      1, 0, 0, 0, 17);
        add(1, 0, 0,      1, 1, 32'h110, 32'h40, 18);
        add(1, 0, 0,      1, 1, 32'h111, 32'h44, 19);
        add(1, 0, 0,      1, 1, 32'h112, 32'h48, 20);

        // Misaligned redirect followed immediately by another redirect
        add(1, 1, 32'h43, 1, 0, 0, 0, 16);
        add(1, 1, 32'h80, 1, 0, 0, 0, 32);
        add(1, 0, 0,      1, 0, 0, 0, 33);
        add(1, 0, 0,      1, 1, 32'h120, 32'h80, 34);
        add(1, 0, 0,      1, 1, 32'h121, 32'h84, 35);
        add(1, 0, 0,      1, 1, 32'h122, 32'h88, 36);

        // Fill the queue with out_ready low, then reset mid-stream
        add(1, 0, 0, 0, 1, 32'h123, 32'h8C, 37);
        add(1, 0, 0, 0, 1, 32'h123, 32'h8C, 37);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1, 32'h100, 32'h0, 2);
        add(1, 0, 0, 1, 1, 32'h101, 32'h4, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n_a              = vecs[i].rst_n;
            bus_a.redirect_valid = vecs[i].rv;
            bus_a.redirect_pc    = vecs[i].rpc;
            bus_a.out_ready      = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(bus_a.out_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d imem_addr", i), 32'(bus_a.imem_addr), 32'(vecs[i].ea));
            if (vecs[i].ev || !vecs[i].rst_n) begin
                chk($sformatf("v%0d out_instr", i), bus_a.out_instr, vecs[i].ei);
                chk($sformatf("v%0d out_pc", i),    bus_a.out_pc,    vecs[i].epc);
            end
        end

        // ---------------- instance B: address wrap ----------------
        @(negedge clk);
        rst_n_b = 1'b1;
        #1;
        chk("wrap c0 addr",  32'(bus_b.imem_addr), 32'd511);
        chk("wrap c0 valid", 32'(bus_b.out_valid), 32'd0);
        @(negedge clk); #1;
        chk("wrap c1 addr",  32'(bus_b.imem_addr), 32'd0);
        chk("wrap c1 valid", 32'(bus_b.out_valid), 32'd0);
        @(negedge clk); #1;
        chk("wrap c2 valid", 32'(bus_b.out_valid), 32'd1);
        chk("wrap c2 instr", bus_b.out_instr, 32'h2FF);
        chk("wrap c2 pc",    bus_b.out_pc,    32'h7FC);
        @(negedge clk); #1;
        chk("wrap c3 valid", 32'(bus_b.out_valid), 32'd1);
        chk("wrap c3 instr", bus_b.out_instr, 32'h100);
        chk("wrap c3 pc",    bus_b.out_pc,    32'h800);
        chk("wrap c3 addr",  32'(bus_b.imem_addr), 32'd2);

        // Reset asserted between clock edges takes effect without a clock
        @(posedge clk); #2;
        rst_n_b = 1'b0;
        #1;
        chk("async rst valid", 32'(bus_b.out_valid), 32'd0);
        chk("async rst instr", bus_b.out_instr, 32'h0);
        chk("async rst pc",    bus_b.out_pc,    32'h0);
        chk("async rst addr",  32'(bus_b.imem_addr), 32'd511);
        @(negedge clk);
        rst_n_b = 1'b1;
        #1;
        chk("restart c0 valid", 32'(bus_b.out_valid), 32'd0);
        @(negedge clk); #1;
        chk("restart c1 valid", 32'(bus_b.out_valid), 32'd0);
        @(negedge clk); #1;
        chk("restart c2 valid", 32'(bus_b.out_valid), 32'd1);
        chk("restart c2 pc",    bus_b.out_pc,    32'h7FC);
        chk("restart c2 instr", bus_b.out_instr, 32'h2FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
